// File: rtl/arbiter_rr_param.sv
// Round-robin arbiter, N requesters, registered one-hot grant with per-owner hold limit.
// Optional owner lock input (hold-limit override) enabled by defining ARB_LOCK_EN.
module arbiter_rr_param #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef ARB_LOCK_EN
    input  logic                 lock,
`endif
    input  logic [N-1:0]         request,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OWNED = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] grant_idx_q, grant_idx_d;
    logic          grant_valid_q, grant_valid_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [IW-1:0] last_owner_q, last_owner_d;

    logic          found;
    logic [IW-1:0] win_idx;
    logic          take;
    logic          lock_hold;
    logic          at_limit;

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign at_limit = (hold_cnt_q >= HW'(MAX_HOLD));

    // Search starts just past last_owner, so the current owner is checked last.
    always_comb begin
        int            j;
        logic [IW-1:0] idx;
        found   = 1'b0;
        win_idx = '0;
        j       = 0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            j   = (int'(last_owner_q) + i) % N;
            idx = IW'(j);
            if (!found && request[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        hold_cnt_d    = hold_cnt_q;
        last_owner_d  = last_owner_q;
        take          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (found) take = 1'b1;
            end
            S_OWNED: begin
                if (request[grant_idx_q] && (!at_limit || lock_hold)) begin
                    if (!at_limit) hold_cnt_d = hold_cnt_q + HW'(1);
                end else if (found) begin
                    take = 1'b1;
                end else begin
                    state_d       = S_IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                end
            end
        endcase

        if (take) begin
            state_d       = S_OWNED;
            grant_d       = N'(1) << win_idx;
            grant_idx_d   = win_idx;
            grant_valid_d = 1'b1;
            hold_cnt_d    = HW'(1);
            last_owner_d  = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            hold_cnt_q    <= '0;
            last_owner_q  <= IW'(N - 1);
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            hold_cnt_q    <= hold_cnt_d;
            last_owner_q  <= last_owner_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;

endmodule
